// File: rtl/fir_mac_filter.sv
// fir_mac_filter: single-multiplier sequential FIR with round-half-up, shift and range limit.
// Define FIR_SATURATE_EN to clamp the result; otherwise it wraps to DATA_W bits.
module fir_mac_filter #(
  parameter int                     DATA_W = 24,
  parameter int                     COEF_W = 16,
  parameter int                     TAPS   = 8,
  parameter logic [TAPS*COEF_W-1:0] COEFFS = '0,
  parameter int                     SHIFT  = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [DATA_W-1:0] iv_din,
  input  logic              i_din_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] ov_dout,
  output logic              o_dout_valid,
  input  logic              i_ready
);

  localparam int ACC_W   = DATA_W + COEF_W + $clog2(TAPS);
  localparam int PROD_W  = DATA_W + COEF_W;
  localparam int CNT_W   = $clog2(TAPS);
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [ACC_W:0] RND = (SHIFT > 0) ? ((ACC_W+1)'(1) << RND_POS) : '0;
`ifdef FIR_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_OUTPUT} state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic signed [DATA_W-1:0]   r_x [TAPS];
  logic signed [ACC_W-1:0]    r_acc;
  logic [CNT_W-1:0]           r_cnt;
  logic [DATA_W-1:0]          r_dout;

  logic signed [COEF_W-1:0]   w_coef [TAPS];
  logic signed [COEF_W-1:0]   w_coef_sel;
  logic signed [DATA_W-1:0]   w_x_sel;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W:0]      w_sum;
  logic signed [ACC_W:0]      w_shr;
  logic [ACC_W-DATA_W+1:0]    w_hi;
  logic                       w_pos_ovf;
  logic                       w_neg_ovf;
  logic                       w_last;
  logic                       w_accept;
  logic [DATA_W-1:0]          w_result;

  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_coef
      assign w_coef[gi] = COEFFS[gi*COEF_W +: COEF_W];
    end
  endgenerate

  assign w_accept   = (r_state == S_IDLE) & i_din_valid & i_en;
  assign w_last     = (r_cnt == CNT_W'(TAPS - 1));
  assign w_coef_sel = w_coef[r_cnt];
  assign w_x_sel    = r_x[r_cnt];
  assign w_prod     = w_coef_sel * w_x_sel;
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

  // One guard bit above the accumulator so adding the rounding constant cannot wrap.
  assign w_sum     = {r_acc[ACC_W-1], r_acc} + RND;
  assign w_shr     = w_sum >>> SHIFT;
  assign w_hi      = w_shr[ACC_W:DATA_W-1];
  assign w_pos_ovf = ~w_shr[ACC_W] & (|w_hi);
  assign w_neg_ovf = w_shr[ACC_W] & ~(&w_hi);

  always_comb begin
    w_result = w_shr[DATA_W-1:0];
    if (SAT_EN && w_pos_ovf) begin
      w_result = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (SAT_EN && w_neg_ovf) begin
      w_result = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end

  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_tap
      if (gi == 0) begin : g_head
        always_ff @(posedge i_clk or negedge i_rst_n) begin
          if (!i_rst_n) begin
            r_x[gi] <= '0;
          end else if (w_accept) begin
            r_x[gi] <= iv_din;
          end
        end
      end else begin : g_shift
        always_ff @(posedge i_clk or negedge i_rst_n) begin
          if (!i_rst_n) begin
            r_x[gi] <= '0;
          end else if (w_accept) begin
            r_x[gi] <= r_x[gi-1];
          end
        end
      end
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (i_din_valid) w_state_next = S_MAC;
      S_MAC:    if (w_last) w_state_next = S_ROUND;
      S_ROUND:  w_state_next = S_OUTPUT;
      S_OUTPUT: if (i_ready) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_dout  <= '0;
    end else if (i_en) begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (i_din_valid) begin
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
        S_ROUND: r_dout <= w_result;
        default: ;
      endcase
    end
  end

  // Ready is forced low while reset is held even though the state already reads IDLE.
  assign o_ready      = i_rst_n & (r_state == S_IDLE);
  assign o_dout_valid = (r_state == S_OUTPUT);
  assign ov_dout      = r_dout;

endmodule

// File: tb/tb_fir_mac_filter.sv
// tb_fir_mac_filter: vector table plus scoreboard for a 4-tap filter, with SHIFT=0 and SHIFT=2 copies.
module tb_fir_mac_filter;
  localparam int DW = 24;
  localparam int CW = 16;
  localparam int NT = 4;
  localparam logic [NT*CW-1:0] CO = {16'd4, 16'd3, 16'd2, 16'd1};

  typedef struct {
    logic [DW-1:0] din;
    logic [DW-1:0] e0w, e0s, e1w, e1s;
  } vec_t;

  typedef struct {
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic din_valid = 1'b0;
  logic rdy = 1'b0;
  logic [DW-1:0] din = '0;
  logic o_ready0, o_valid0, o_ready1, o_valid1;
  logic [DW-1:0] dout0, dout1;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   sb_on = 1'b0;
  exp_t sbq[$];

  fir_mac_filter #(.DATA_W(DW), .COEF_W(CW), .TAPS(NT), .COEFFS(CO), .SHIFT(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .iv_din(din), .i_din_valid(din_valid),
    .o_ready(o_ready0), .ov_dout(dout0), .o_dout_valid(o_valid0), .i_ready(rdy)
  );

  fir_mac_filter #(.DATA_W(DW), .COEF_W(CW), .TAPS(NT), .COEFFS(CO), .SHIFT(2)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .iv_din(din), .i_din_valid(din_valid),
    .o_ready(o_ready1), .ov_dout(dout1), .o_dout_valid(o_valid1), .i_ready(rdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  function automatic vec_t mk(input logic [DW-1:0] d, input logic [DW-1:0] e0w,
                              input logic [DW-1:0] e0s, input logic [DW-1:0] e1w,
                              input logic [DW-1:0] e1s);
    vec_t v;
    v.din = d; v.e0w = e0w; v.e0s = e0s; v.e1w = e1w; v.e1s = e1s;
    return v;
  endfunction

  function automatic exp_t pick(input vec_t v);
    exp_t e;
`ifdef FIR_SATURATE_EN
    e.e0 = v.e0s; e.e1 = v.e1s;
`else
    e.e0 = v.e0w; e.e1 = v.e1w;
`endif
    return e;
  endfunction

  function automatic exp_t ex(input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    exp_t e;
    e.e0 = e0; e.e1 = e1;
    return e;
  endfunction

  // Drives one sample once the filter is ready; returns the cycle index of the accepting edge.
  task automatic send(input logic [DW-1:0] d, output int t_acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_ready0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready0) begin
      checks++; errors++;
      $display("FAIL send_ready: o_ready=0 after %0d cycles, required 1", n);
    end
    din = d;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    t_acc = cyc;
    din_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", sbq.size(), 0);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!o_valid0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_on && rst_n && en && rdy && o_valid0) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected: output 0x%0h with no expected entry", dout0);
        end else begin
          e = sbq.pop_front();
          check("sb_dout_shift0", int'(dout0), int'(e.e0));
          check("sb_dout_shift2", int'(dout1), int'(e.e1));
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t tv[24];
    int ta, tprev, n;

    tv[0]  = mk(24'h000001, 24'h000001, 24'h000001, 24'h000000, 24'h000000);
    tv[1]  = mk(24'h000000, 24'h000002, 24'h000002, 24'h000001, 24'h000001);
    tv[2]  = mk(24'h000000, 24'h000003, 24'h000003, 24'h000001, 24'h000001);
    tv[3]  = mk(24'h000000, 24'h000004, 24'h000004, 24'h000001, 24'h000001);
    tv[4]  = mk(24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h000000);
    tv[5]  = mk(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000000);
    tv[6]  = mk(24'h000000, 24'hFFFFFE, 24'hFFFFFE, 24'h000000, 24'h000000);
    tv[7]  = mk(24'h000000, 24'hFFFFFD, 24'hFFFFFD, 24'hFFFFFF, 24'hFFFFFF);
    tv[8]  = mk(24'h000000, 24'hFFFFFC, 24'hFFFFFC, 24'hFFFFFF, 24'hFFFFFF);
    tv[9]  = mk(24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h000000);
    tv[10] = mk(24'h000002, 24'h000002, 24'h000002, 24'h000001, 24'h000001);
    tv[11] = mk(24'h000000, 24'h000004, 24'h000004, 24'h000001, 24'h000001);
    tv[12] = mk(24'h000000, 24'h000006, 24'h000006, 24'h000002, 24'h000002);
    tv[13] = mk(24'h000000, 24'h000008, 24'h000008, 24'h000002, 24'h000002);
    tv[14] = mk(24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h000000);
    tv[15] = mk(24'hFFFFFD, 24'hFFFFFD, 24'hFFFFFD, 24'hFFFFFF, 24'hFFFFFF);
    tv[16] = mk(24'h000000, 24'hFFFFFA, 24'hFFFFFA, 24'hFFFFFF, 24'hFFFFFF);
    tv[17] = mk(24'h000000, 24'hFFFFF7, 24'hFFFFF7, 24'hFFFFFE, 24'hFFFFFE);
    tv[18] = mk(24'h000000, 24'hFFFFF4, 24'hFFFFF4, 24'hFFFFFD, 24'hFFFFFD);
    tv[19] = mk(24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h000000);
    tv[20] = mk(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h200000, 24'h200000);
    tv[21] = mk(24'h7FFFFF, 24'h7FFFFD, 24'h7FFFFF, 24'h5FFFFF, 24'h5FFFFF);
    tv[22] = mk(24'h7FFFFF, 24'hFFFFFA, 24'h7FFFFF, 24'hBFFFFF, 24'h7FFFFF);
    tv[23] = mk(24'h7FFFFF, 24'hFFFFF6, 24'h7FFFFF, 24'h3FFFFE, 24'h7FFFFF);

    // Reset state.
    en = 1'b1;
    rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_o_ready", int'(o_ready0), 0);
    check("reset_o_dout_valid", int'(o_valid0), 0);
    check("reset_ov_dout", int'(dout0), 0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_o_ready", int'(o_ready0), 1);

    // Accept-to-valid latency.
    sb_on = 1'b1;
    sbq.push_back(ex(24'h0, 24'h0));
    send(24'h0, ta);
    wait_valid(n);
    check("latency_edges", n, NT + 1);
    drain();

    // Vector table, back to back with i_ready high.
    tprev = 0;
    for (int i = 0; i < 24; i++) begin
      sbq.push_back(pick(tv[i]));
      send(tv[i].din, ta);
      if (i > 0) check("accept_spacing", ta - tprev, NT + 3);
      tprev = ta;
    end
    drain();

    // Backpressure with a sample waiting upstream.
    sb_on = 1'b0;
    do_reset();
    rdy = 1'b0;
    send(24'd5, ta);
    wait_valid(n);
    check("bp_valid_rise", n, NT + 1);
    @(negedge clk);
    din = 24'd9;
    din_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_hold_valid", int'(o_valid0), 1);
      check("bp_hold_dout", int'(dout0), 5);
      check("bp_hold_ready", int'(o_ready0), 0);
    end
    check("bp_hold_dout_shift2", int'(dout1), 1);
    rdy = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", int'(o_valid0), 0);
    check("bp_release_ready", int'(o_ready0), 1);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    check("bp_held_sample_taken", int'(o_ready0), 0);
    wait_valid(n);
    check("bp_second_dout", int'(dout0), 19);
    check("bp_second_dout_shift2", int'(dout1), 5);

    // Reset in the middle of MAC, then a clean impulse.
    send(24'd7, ta);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_o_ready", int'(o_ready0), 0);
    check("midrst_o_dout_valid", int'(o_valid0), 0);
    check("midrst_ov_dout", int'(dout0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_idle_ready", int'(o_ready0), 1);
    sb_on = 1'b1;
    sbq.push_back(ex(24'd1, 24'd0));
    sbq.push_back(ex(24'd2, 24'd1));
    sbq.push_back(ex(24'd3, 24'd1));
    sbq.push_back(ex(24'd4, 24'd1));
    send(24'd1, ta);
    send(24'd0, ta);
    send(24'd0, ta);
    send(24'd0, ta);
    drain();

    // Clock enable low for 3 cycles mid-MAC, then low again while output is offered.
    sb_on = 1'b0;
    send(24'd3, ta);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    wait_valid(n);
    check("en_gated_latency", cyc - ta, NT + 1 + 3);
    check("en_gated_dout", int'(dout0), 3);
    en = 1'b0;
    @(posedge clk);
    #1;
    check("en_freeze_valid", int'(o_valid0), 1);
    @(posedge clk);
    #1;
    check("en_freeze_dout", int'(dout0), 3);
    check("en_freeze_ready", int'(o_ready0), 0);
    en = 1'b1;
    @(posedge clk);
    #1;
    check("en_resume_valid", int'(o_valid0), 0);
    check("en_resume_ready", int'(o_ready0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
